// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller with HI/LO result registers.
//
// The product or quotient/remainder of a mult/multu/div/divu is computed
// and captured when the operation is accepted. It is then held back for a
// fixed number of busy cycles before it is committed to HI/LO, which gives
// the pipeline the same timing as an iterative multiplier/divider.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous, active-high reset
//   A       in  32   rs operand (dividend / multiplicand / mthi-mtlo data)
//   B       in  32   rt operand (divisor / multiplier)
//   MDUOp   in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                    6 mtlo, 7 mfhi, 8 mflo, others none
//   Req     in   1   exception/interrupt flush of the presenting instruction
//   Busy    out  1   high while a mult/div is in flight
//   Start   out  1   a mult/div is being accepted this cycle
//   MDUOut  out 32   HI on mfhi, LO on mflo, else 0 (combinational)
//
// Configuration macro
//   MDU_DIV0_GUARD_EN  defined: div/divu by zero still takes DIV_CYCLES but
//                      leaves HI/LO unchanged. Undefined: HI=A,
//                      LO=32'hFFFFFFFF at completion.
// ---------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Req,
    output logic        Busy,
    output logic        Start,
    output logic [31:0] MDUOut
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [63:0]      res_q,   res_d;
    logic             res_wr_q, res_wr_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    // ---------------------------------------------------------------------
    // Operation decode
    // ---------------------------------------------------------------------
    logic is_mul;
    logic is_div;
    logic is_md;
    logic div_by_zero;

    assign is_mul      = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign is_div      = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign is_md       = is_mul || is_div;
    assign div_by_zero = (B == '0);

    assign Busy  = (state_q == RUN);
    assign Start = is_md && !Req && !Busy;

    // ---------------------------------------------------------------------
    // Arithmetic datapath
    // ---------------------------------------------------------------------
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'b0, A} * {32'b0, B};
    // Verilog signed division truncates toward zero and the remainder takes
    // the dividend's sign, which is exactly the MIPS div definition.
    assign quot_s = $signed(A) / $signed(B);
    assign rem_s  = $signed(A) % $signed(B);
    assign quot_u = A / B;
    assign rem_u  = A % B;

    // Result captured at acceptance ({HI, LO}) and whether it may be written.
    logic [63:0] new_res;
    logic        new_wr;

    always_comb begin
        new_res = '0;
        new_wr  = 1'b1;
        unique case (MDUOp)
            OP_MULT:  new_res = prod_s;
            OP_MULTU: new_res = prod_u;
            OP_DIV,
            OP_DIVU: begin
                if (div_by_zero) begin
`ifdef MDU_DIV0_GUARD_EN
                    new_wr  = 1'b0;
`else
                    new_res = {A, 32'hFFFF_FFFF};
`endif
                end else if (MDUOp == OP_DIV) begin
                    new_res = {rem_s, quot_s};
                end else begin
                    new_res = {rem_u, quot_u};
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM next state / HI-LO update
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_wr_d = res_wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = RUN;
                    cnt_d    = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    res_d    = new_res;
                    res_wr_d = new_wr;
                end else if (!Req) begin
                    if (MDUOp == OP_MTHI) hi_d = A;
                    if (MDUOp == OP_MTLO) lo_d = A;
                end
            end
            RUN: begin
                // The counter holds the number of busy cycles still to go,
                // including the current one; the last one commits HI/LO.
                // Any op issued meanwhile is stalled upstream and ignored.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (res_wr_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            res_q    <= '0;
            res_wr_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_wr_q <= res_wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // ---------------------------------------------------------------------
    // Read port: always the committed HI/LO, so RUN shows pre-update values.
    // ---------------------------------------------------------------------
    always_comb begin
        MDUOut = '0;
        if (MDUOp == OP_MFHI) MDUOut = hi_q;
        else if (MDUOp == OP_MFLO) MDUOut = lo_q;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 A  input  32  operand rs (dividend / multiplicand / mthi-mtlo data).
REQ-006 B  input  32  operand rt (divisor / multiplier).
REQ-007 MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others treated as none.
REQ-008 Req  input  1  exception/interrupt flush for the instruction currently presenting MDUOp.
REQ-009 Busy  output  1  high while a mult/div is in flight.
REQ-010 Start  output  1  combinational: high when MDUOp is 1-4, Req=0 and Busy=0.
REQ-011 MDUOut  output  32  combinational read: HI when MDUOp=7, LO when MDUOp=8, else 0.

Function
REQ-012 Two-state FSM: IDLE, RUN; Busy SHALL be high only in RUN.
REQ-013 In IDLE with Start=1 at edge t: latch the full 64-bit result internally, load a down-counter with N (MULT_CYCLES or DIV_CYCLES), go to RUN.
REQ-014 Busy SHALL be high for exactly N cycles after edge t; HI/LO are written at edge t+N, and the FSM returns to IDLE at that same edge.
REQ-015 mult: {HI,LO} = signed A * signed B; multu: unsigned 64-bit product.
REQ-016 div: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign; divu: unsigned quotient/remainder.
REQ-017 mthi/mtlo with Req=0 and Busy=0: HI (resp. LO) <= A at the next edge; no busy cycles.
REQ-018 Any MDUOp 1-6 presented while Busy=1 SHALL be ignored (the hazard unit stalls it; no state change).
REQ-019 Req=1 SHALL suppress start and mthi/mtlo for that cycle; an operation already in RUN SHALL continue and complete normally.
REQ-020 MDUOut during RUN SHALL show the old HI/LO (pre-update values).
REQ-021 Back-to-back: a new Start is accepted in the cycle after Busy falls (first IDLE cycle), never in the completion cycle.
REQ-022 Counter width SHALL hold max(MULT_CYCLES, DIV_CYCLES); both parameters SHALL be at least 1.

Reset
REQ-023 reset=1 at an edge: state IDLE, counter 0, HI=0, LO=0, internal result register 0; Busy=0 from that edge on.
REQ-024 Reset during RUN SHALL discard the pending result; HI/LO stay 0.
REQ-025 reset has priority over Start, mthi/mtlo and completion in the same cycle.

Configuration
REQ-026 Macro MDU_DIV0_GUARD_EN defined: div/divu with B=0 SHALL still take DIV_CYCLES busy cycles but leave HI and LO unchanged.
REQ-027 Macro not defined: div/divu with B=0 SHALL write HI=A and LO=32'hFFFFFFFF at completion.

Verification
REQ-028 mult A=32'hFFFFFFFE (-2), B=3 -> Busy high 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; mfhi/mflo read these.
REQ-029 divu A=100, B=7 -> Busy high 10 cycles; LO=14, HI=2; div A=-7 (32'hFFFFFFF9), B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-030 mthi A=32'h12345678 with Req=1 -> HI unchanged; repeat with Req=0 -> HI=32'h12345678 after one edge, Busy stays 0.
REQ-031 Start mult, assert reset on the 3rd busy cycle -> Busy=0, HI=LO=0, no later write.
REQ-032 divu B=0 with HI=LO=5 beforehand -> guard defined: HI=LO=5; guard undefined: HI=A, LO=32'hFFFFFFFF.
REQ-033 multu presented on the completion cycle of a div -> ignored; presented in the next cycle -> accepted, Busy high 5 cycles.
